// File: rtl/viterbi_dec_acs.sv
// rtl/viterbi_dec_acs.sv - rate-1/2 hard-decision Viterbi decoder, ACS with register-exchange survivors
// Optional o_err_cnt output is enabled by defining VITERBI_ERR_CNT_EN.
module viterbi_dec_acs #(
  parameter int               P_K        = 3,
  parameter logic [P_K-1:0]   P_POLY_0   = 3'b111,
  parameter logic [P_K-1:0]   P_POLY_1   = 3'b101,
  parameter int               P_TB_DEPTH = 15,
  parameter int               P_METRIC_W = 6
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [1:0]            i_data,
  input  logic [1:0]            i_valid,
  output logic                  o_data,
  output logic                  o_valid,
  output logic                  o_error,
`ifdef VITERBI_ERR_CNT_EN
  output logic [15:0]           o_err_cnt,
`endif
  output logic [P_METRIC_W-1:0] o_metric
);

  localparam int S_W = P_K - 1;
  localparam int N   = 1 << S_W;
  localparam int D   = P_TB_DEPTH;
  localparam int W   = P_METRIC_W;
  localparam int F_W = $clog2(D + 1);
  localparam logic [W-1:0]   PM_INIT  = W'(1 << (W - 2));
  localparam logic [F_W-1:0] FILL_MAX = F_W'(D);

  logic [W-1:0]   pm_q [N];
  logic [W-1:0]   pm_d [N];
  logic [W-1:0]   acs_pm [N];
  logic [D-1:0]   surv_q [N];
  logic [D-1:0]   surv_d [N];
  logic [D-1:0]   acs_surv [N];
  logic [F_W-1:0] fill_q, fill_d;
  logic           data_q, data_d;
  logic           valid_q, valid_d;
  logic           error_q, error_d;
  logic [W-1:0]   metric_q, metric_d;
  logic           accept;
  logic           all_msb;
  logic [S_W-1:0] best;
  logic [W-1:0]   min_pm;
  logic           zero_branch;

  assign accept = (i_valid != 2'b00);

  // Erased bits are masked out of the Hamming distance.
  function automatic logic [1:0] branch_metric(input logic [P_K-1:0] r,
                                               input logic [1:0] d,
                                               input logic [1:0] v);
    logic c0, c1;
    c0 = ^(r & P_POLY_0);
    c1 = ^(r & P_POLY_1);
    return {1'b0, v[0] & (c0 ^ d[0])} + {1'b0, v[1] & (c1 ^ d[1])};
  endfunction

  function automatic logic [W-1:0] sat_add(input logic [W-1:0] a, input logic [1:0] b);
    logic [W:0] sum;
    sum = {1'b0, a} + {{(W-1){1'b0}}, b};
    return sum[W] ? {W{1'b1}} : sum[W-1:0];
  endfunction

  always_comb begin
    logic [S_W-1:0] ns, p0, p1;
    logic [W-1:0]   c0, c1;
    ns = '0;
    p0 = '0;
    p1 = '0;
    c0 = '0;
    c1 = '0;
    all_msb = 1'b1;
    for (int i = 0; i < N; i++) begin
      ns = S_W'(i);
      p0 = {1'b0, ns[S_W-1:1]};
      p1 = {1'b1, ns[S_W-1:1]};
      c0 = sat_add(pm_q[p0], branch_metric({p0, ns[0]}, i_data, i_valid));
      c1 = sat_add(pm_q[p1], branch_metric({p1, ns[0]}, i_data, i_valid));
      if (c1 < c0) begin
        acs_pm[i]   = c1;
        acs_surv[i] = {surv_q[p1][D-2:0], ns[0]};
      end else begin
        acs_pm[i]   = c0;
        acs_surv[i] = {surv_q[p0][D-2:0], ns[0]};
      end
      all_msb = all_msb & acs_pm[i][W-1];
    end
  end

  // Best state and error flag look at the metrics before this symbol is folded in.
  always_comb begin
    min_pm = pm_q[0];
    best   = '0;
    for (int i = 1; i < N; i++) begin
      if (pm_q[i] < min_pm) begin
        min_pm = pm_q[i];
        best   = S_W'(i);
      end
    end
    zero_branch = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (pm_q[i] == min_pm &&
          (branch_metric({S_W'(i), 1'b0}, i_data, i_valid) == 2'd0 ||
           branch_metric({S_W'(i), 1'b1}, i_data, i_valid) == 2'd0))
        zero_branch = 1'b1;
    end
  end

  always_comb begin
    pm_d     = pm_q;
    surv_d   = surv_q;
    fill_d   = fill_q;
    data_d   = data_q;
    metric_d = metric_q;
    valid_d  = 1'b0;
    error_d  = 1'b0;
    if (accept) begin
      for (int i = 0; i < N; i++)
        pm_d[i] = all_msb ? {1'b0, acs_pm[i][W-2:0]} : acs_pm[i];
      surv_d   = acs_surv;
      fill_d   = (fill_q == FILL_MAX) ? fill_q : fill_q + F_W'(1);
      data_d   = surv_q[best][D-1];
      metric_d = min_pm;
      error_d  = ~zero_branch;
      valid_d  = (fill_q == FILL_MAX);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < N; i++) begin
        pm_q[i]   <= (i == 0) ? '0 : PM_INIT;
        surv_q[i] <= '0;
      end
      fill_q   <= '0;
      data_q   <= 1'b0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
      metric_q <= '0;
    end else begin
      pm_q     <= pm_d;
      surv_q   <= surv_d;
      fill_q   <= fill_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
      metric_q <= metric_d;
    end
  end

  assign o_data   = data_q;
  assign o_valid  = valid_q;
  assign o_error  = error_q;
  assign o_metric = metric_q;

`ifdef VITERBI_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (error_q && err_cnt_q != 16'hFFFF)
      err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset)
      err_cnt_q <= '0;
    else
      err_cnt_q <= err_cnt_d;
  end

  assign o_err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_viterbi_dec_acs.sv
// tb/tb_viterbi_dec_acs.sv - bench for viterbi_dec_acs against a traceback Viterbi model
// Honours VITERBI_ERR_CNT_EN when defined.
module tb_viterbi_dec_acs;

  localparam int N    = 4;
  localparam int D    = 15;
  localparam int MAXM = 63;
  localparam int HALF = 32;
  localparam int INIT = 16;
  localparam int NSYM = 202;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic [1:0] i_data;
  logic [1:0] i_valid;
  logic       o_data;
  logic       o_valid;
  logic       o_error;
  logic [5:0] o_metric;
`ifdef VITERBI_ERR_CNT_EN
  logic [15:0] o_err_cnt;
`endif

  viterbi_dec_acs #(
    .P_K(3), .P_POLY_0(3'b111), .P_POLY_1(3'b101), .P_TB_DEPTH(15), .P_METRIC_W(6)
  ) dut (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .i_data(i_data),
    .i_valid(i_valid),
    .o_data(o_data),
    .o_valid(o_valid),
    .o_error(o_error),
`ifdef VITERBI_ERR_CNT_EN
    .o_err_cnt(o_err_cnt),
`endif
    .o_metric(o_metric)
  );

  always #5 i_clk = ~i_clk;

  int   checks;
  int   failures;
  int   m_pm [N];
  int   hist [0:511][0:3];
  int   m_cnt;
  logic m_valid, m_data, m_err;
  int   m_metric;
  int   m_errcnt;
  int   bits [0:NSYM-1];
  int   gold_q [$];
  int   n_out;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Encoder: register = {state, b}, newest bit in the LSB.
  function automatic logic [1:0] enc(input int s, input int b);
    int r;
    r = s * 2 + b;
    return {($countones(r & 5) % 2) == 1, ($countones(r & 7) % 2) == 1};
  endfunction

  function automatic int bm_m(input int s, input int b, input logic [1:0] d, input logic [1:0] v);
    logic [1:0] e;
    e = enc(s, b);
    return int'(v[0] && e[0] != d[0]) + int'(v[1] && e[1] != d[1]);
  endfunction

  task automatic model_reset();
    m_pm[0] = 0;
    for (int i = 1; i < N; i++) m_pm[i] = INIT;
    m_cnt = 0; m_valid = 0; m_data = 0; m_err = 0; m_metric = 0; m_errcnt = 0;
  endtask

  task automatic model_accept(input logic [1:0] d, input logic [1:0] v);
    int mn, best, s, p0, p1, c0, c1;
    int np [N];
    bit all_hi;
    mn = m_pm[0]; best = 0;
    for (int i = 1; i < N; i++) if (m_pm[i] < mn) begin mn = m_pm[i]; best = i; end
    m_err = 1;
    for (int i = 0; i < N; i++)
      for (int b = 0; b < 2; b++)
        if (m_pm[i] == mn && bm_m(i, b, d, v) == 0) m_err = 0;
    m_metric = mn;
    m_valid  = (m_cnt >= D);
    if (m_valid) begin
      s = best;
      for (int j = m_cnt - 1; j >= m_cnt - D + 1; j--) s = hist[j][s];
      m_data = (s % 2) == 1;
    end
    all_hi = 1;
    for (int ns = 0; ns < N; ns++) begin
      p0 = ns / 2;
      p1 = p0 + N / 2;
      c0 = m_pm[p0] + bm_m(p0, ns % 2, d, v); if (c0 > MAXM) c0 = MAXM;
      c1 = m_pm[p1] + bm_m(p1, ns % 2, d, v); if (c1 > MAXM) c1 = MAXM;
      if (c1 < c0) begin np[ns] = c1; hist[m_cnt][ns] = p1; end
      else         begin np[ns] = c0; hist[m_cnt][ns] = p0; end
      if (np[ns] < HALF) all_hi = 0;
    end
    for (int ns = 0; ns < N; ns++) m_pm[ns] = all_hi ? np[ns] - HALF : np[ns];
    m_cnt++;
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_reset = 1'b1; i_valid = 2'b00; i_data = 2'b00;
    @(posedge i_clk); #1;
    model_reset();
    chk("rst_o_valid", 32'(o_valid), 32'd0);
    chk("rst_o_data", 32'(o_data), 32'd0);
    chk("rst_o_error", 32'(o_error), 32'd0);
    chk("rst_o_metric", 32'(o_metric), 32'd0);
`ifdef VITERBI_ERR_CNT_EN
    chk("rst_o_err_cnt", 32'(o_err_cnt), 32'd0);
`endif
  endtask

  task automatic step(input logic [1:0] d, input logic [1:0] v);
`ifdef VITERBI_ERR_CNT_EN
    logic prev_err;
    prev_err = m_err;
`endif
    @(negedge i_clk);
    i_reset = 1'b0; i_data = d; i_valid = v;
    if (v != 2'b00) model_accept(d, v);
    else begin m_valid = 0; m_err = 0; end
`ifdef VITERBI_ERR_CNT_EN
    if (prev_err && m_errcnt < 65535) m_errcnt++;
`endif
    @(posedge i_clk); #1;
    chk("o_valid", 32'(o_valid), 32'(m_valid));
    chk("o_error", 32'(o_error), 32'(m_err));
    chk("o_metric", 32'(o_metric), 32'(m_metric));
`ifdef VITERBI_ERR_CNT_EN
    chk("o_err_cnt", 32'(o_err_cnt), 32'(m_errcnt));
`endif
    if (m_valid) begin
      n_out++;
      chk("o_data_model", 32'(o_data), 32'(m_data));
      chk("gold_avail", 32'(gold_q.size() > 0), 32'd1);
      if (gold_q.size() > 0) chk("o_data_golden", 32'(o_data), 32'(gold_q.pop_front()));
    end
  endtask

  task automatic gen_bits();
    for (int i = 0; i < NSYM; i++) bits[i] = (i < NSYM - 2) ? int'($urandom_range(0, 1)) : 0;
  endtask

  // mode 0 clean, 1 c0 flipped at symbol 50, 2 c1 erased every 4th symbol, 3 random gaps
  task automatic run_stream(input int mode, input int n_sym);
    logic [1:0] sym, v;
    int s;
    s = 0;
    gold_q.delete();
    for (int i = 0; i < NSYM; i++) gold_q.push_back(bits[i]);
    n_out = 0;
    for (int i = 0; i < n_sym; i++) begin
      sym = enc(s, bits[i]);
      s = (s * 2 + bits[i]) % N;
      v = 2'b11;
      if (mode == 1 && i == 49) sym[0] = ~sym[0];
      if (mode == 2 && i % 4 == 3) begin v = 2'b01; sym[1] = 1'($urandom_range(0, 1)); end
      if (mode == 3)
        for (int g = 0; g < 3 && $urandom_range(0, 3) == 0; g++) step(2'($urandom_range(0, 3)), 2'b00);
      step(sym, v);
      chk("o_error_golden", 32'(o_error), 32'(mode == 1 && i == 49));
      chk("o_metric_golden", 32'(o_metric), 32'(mode == 1 && i >= 50));
    end
    if (n_sym == NSYM) chk("n_out", 32'(n_out), 32'(NSYM - D));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0;
    i_reset = 1'b0; i_data = 2'b00; i_valid = 2'b00;
    model_reset();
    n_out = 0;

    do_reset();
    gold_q.delete();
    for (int i = 0; i < 40; i++) gold_q.push_back(0);
    for (int i = 0; i < 40; i++) begin
      step(2'b00, 2'b11);
      chk("zero_o_valid", 32'(o_valid), 32'(i >= D));
      chk("zero_o_error", 32'(o_error), 32'd0);
      chk("zero_o_metric", 32'(o_metric), 32'd0);
    end
    chk("zero_n_out", 32'(n_out), 32'd25);

    gen_bits();
    do_reset(); run_stream(0, NSYM);
    do_reset(); run_stream(1, NSYM);
    do_reset(); run_stream(2, NSYM);
    do_reset(); run_stream(3, NSYM);

    do_reset(); run_stream(0, 100);
    gen_bits();
    do_reset(); run_stream(0, NSYM);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
